tri_raster_scan: RTL and testbench

- Parametrised successor to the fixed 3-bit triangle rasteriser.
- Accepts three vertices of arbitrary orientation and ordering on a 2^W x 2^W unsigned grid. It scans the triangle's bounding box in raster order and emits one pixel per accepted cycle, with an inside/outside flag.
- Adds a downstream ready/valid handshake with backpressure, a selectable edge-inclusion rule and a completion pulse.
- Sits between the vertex source and the pixel writer in the rasterisation path.

---
 rtl/tri_raster_scan.sv | 159 +++++++++++++++
 tb/tb_tri_raster_scan.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tri_raster_scan.sv
// Triangle rasteriser: captures three vertices, scans their bounding box in raster
// order and streams one pixel per accepted cycle with an inside/outside flag.
module tri_raster_scan #(
  parameter int unsigned W            = 3,
  parameter bit          INCLUDE_EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         nt,
  input  logic [W-1:0] xi,
  input  logic [W-1:0] yi,
  output logic         busy,
  output logic         ov,
  input  logic         ordy,
  output logic         po,
  output logic [W-1:0] xo,
  output logic [W-1:0] yo,
  output logic         done
);

  localparam int unsigned PW = 2 * W + 2;
  localparam int unsigned EW = 2 * W + 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET2  = 3'd1,
    S_GET3  = 3'd2,
    S_SETUP = 3'd3,
    S_SCAN  = 3'd4
  } state_e;

  state_e       state_q;
  logic [W-1:0] x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
  logic [W-1:0] xmin_q, xmax_q, ymax_q;
  logic [W-1:0] x_q, y_q;
  logic         busy_q, ov_q, done_q;

  logic signed [EW-1:0] e12_c, e23_c, e31_c;
  logic [2:0]           pos_c, neg_c;
  logic                 inside_c;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // E_ab(p) = (xb-xa)*(py-ya) - (yb-ya)*(px-xa); every intermediate fits without overflow
  function automatic logic signed [EW-1:0] edge_fn(
    input logic [W-1:0] ax, input logic [W-1:0] ay,
    input logic [W-1:0] bx, input logic [W-1:0] by,
    input logic [W-1:0] px, input logic [W-1:0] py);
    logic signed [PW-1:0] dx, dy, qx, qy, m1, m2;
    dx = $signed(PW'(bx)) - $signed(PW'(ax));
    dy = $signed(PW'(by)) - $signed(PW'(ay));
    qx = $signed(PW'(px)) - $signed(PW'(ax));
    qy = $signed(PW'(py)) - $signed(PW'(ay));
    m1 = dx * qy;
    m2 = dy * qx;
    return $signed({m1[PW-1], m1}) - $signed({m2[PW-1], m2});
  endfunction

  always_comb begin
    e12_c = edge_fn(x1_q, y1_q, x2_q, y2_q, x_q, y_q);
    e23_c = edge_fn(x2_q, y2_q, x3_q, y3_q, x_q, y_q);
    e31_c = edge_fn(x3_q, y3_q, x1_q, y1_q, x_q, y_q);
    neg_c = {e12_c[EW-1], e23_c[EW-1], e31_c[EW-1]};
    pos_c = {~e12_c[EW-1] & (e12_c != '0),
             ~e23_c[EW-1] & (e23_c != '0),
             ~e31_c[EW-1] & (e31_c != '0)};
    // Orientation-independent: accept either winding
    if (INCLUDE_EDGE) inside_c = (&(~neg_c)) | (&(~pos_c));
    else              inside_c = (&pos_c) | (&neg_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      x3_q    <= '0;
      y3_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (nt) begin
            x1_q    <= xi;
            y1_q    <= yi;
            busy_q  <= 1'b1;
            state_q <= S_GET2;
          end
        end
        S_GET2: begin
          x2_q    <= xi;
          y2_q    <= yi;
          state_q <= S_GET3;
        end
        S_GET3: begin
          x3_q    <= xi;
          y3_q    <= yi;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          xmin_q  <= min3(x1_q, x2_q, x3_q);
          xmax_q  <= max3(x1_q, x2_q, x3_q);
          ymax_q  <= max3(y1_q, y2_q, y3_q);
          x_q     <= min3(x1_q, x2_q, x3_q);
          y_q     <= min3(y1_q, y2_q, y3_q);
          ov_q    <= 1'b1;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          // Increments are bounded by the box maxima, so no wrap at 2^W-1
          if (ordy) begin
            if (x_q < xmax_q) begin
              x_q <= x_q + W'(1);
            end else if (y_q < ymax_q) begin
              x_q <= xmin_q;
              y_q <= y_q + W'(1);
            end else begin
              ov_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign ov   = ov_q;
  assign done = done_q;
  assign xo   = x_q;
  assign yo   = y_q;
  assign po   = ov_q & inside_c;

endmodule

// File: tb/tb_tri_raster_scan.sv
// Directed bench for tri_raster_scan: an edge-inclusive and a strict instance share stimulus.
module tb_tri_raster_scan;

  localparam int unsigned W = 3;

  logic         clk;
  logic         reset_n;
  logic         nt;
  logic [W-1:0] xi, yi;
  logic         ordy;
  logic         busy, ov, po, done;
  logic [W-1:0] xo, yo;
  logic         busy_s, ov_s, po_s, done_s;
  logic [W-1:0] xo_s, yo_s;

  int n_checks = 0;
  int n_pass   = 0;

  tri_raster_scan #(.W(W), .INCLUDE_EDGE(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .nt(nt), .xi(xi), .yi(yi),
    .busy(busy), .ov(ov), .ordy(ordy), .po(po), .xo(xo), .yo(yo), .done(done)
  );

  tri_raster_scan #(.W(W), .INCLUDE_EDGE(1'b0)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .nt(nt), .xi(xi), .yi(yi),
    .busy(busy_s), .ov(ov_s), .ordy(ordy), .po(po_s), .xo(xo_s), .yo(yo_s), .done(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Hand-derived inside predicates for each test triangle
  function automatic int exp_po(input int id, input int x, input int y, input bit strict);
    int r;
    r = 0;
    case (id)
      0: r = strict ? int'(x > 0 && y > 0 && x + y < 4) : int'(x + y <= 4);
      1: r = strict ? int'(x + y > 7 && x < 7 && y < 7) : int'(x + y >= 7);
      2: r = strict ? 0 : 1;
      3: r = strict ? 0 : int'(x == y);
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic send_tri(input int x1, input int y1, input int x2, input int y2,
                          input int x3, input int y3);
    @(negedge clk);
    nt = 1'b1; xi = W'(x1); yi = W'(y1);
    @(negedge clk);
    check_eq("get2_busy", int'(busy), 1);
    nt = 1'b0; xi = W'(x2); yi = W'(y2);
    @(negedge clk);
    xi = W'(x3); yi = W'(y3);
    @(negedge clk);
    check_eq("setup_ov", int'(ov), 0);
    check_eq("setup_busy", int'(busy), 1);
  endtask

  task automatic scan_tri(input int id, input int xmin, input int xmax, input int ymin,
                          input int ymax, input int exp_in, input int exp_in_s,
                          input int stall_at, input bit poke_nt, input int abort_at);
    int ex, ey, n, pin, pst, stalls, cyc;
    bit fin;
    ex = xmin; ey = ymin; n = 0; pin = 0; pst = 0; stalls = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (n == abort_at) return;
      check_eq("scan_ov", int'(ov), 1);
      check_eq("scan_xo", int'(xo), ex);
      check_eq("scan_yo", int'(yo), ey);
      check_eq("scan_po", int'(po), exp_po(id, ex, ey, 1'b0));
      check_eq("scan_po_strict", int'(po_s), exp_po(id, ex, ey, 1'b1));
      check_eq("scan_done", int'(done), 0);
      check_eq("strict_lane", int'({ov_s, busy_s, done_s, xo_s, yo_s}),
               int'({1'b1, 1'b1, 1'b0, W'(ex), W'(ey)}));
      nt = poke_nt && (n == 2);
      if (n == stall_at && stalls < 3) begin
        ordy = 1'b0;
        stalls++;
      end else begin
        ordy = 1'b1;
        if (po) pin++;
        if (po_s) pst++;
        n++;
        if (ex < xmax) ex++;
        else if (ey < ymax) begin ex = xmin; ey++; end
        else fin = 1'b1;
      end
    end
    nt = 1'b0;
    if (!fin) check_eq("scan_timeout", 0, 1);
    check_eq("inside_count", pin, exp_in);
    check_eq("inside_count_strict", pst, exp_in_s);
    @(negedge clk);
    check_eq("done_pulse", int'(done), 1);
    check_eq("done_pulse_strict", int'(done_s), 1);
    check_eq("end_ov", int'(ov), 0);
    check_eq("end_busy", int'(busy), 0);
    @(negedge clk);
    check_eq("done_clear", int'(done), 0);
  endtask

  initial begin
    reset_n = 1'b0; nt = 1'b0; xi = '0; yi = '0; ordy = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ov", int'(ov), 0);
    check_eq("rst_po", int'(po), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_xo", int'(xo), 0);
    check_eq("rst_yo", int'(yo), 0);
    reset_n = 1'b1;

    // Right triangle, both vertex orders; second run adds backpressure and a stray nt
    send_tri(0, 0, 4, 0, 0, 4);
    scan_tri(0, 0, 4, 0, 4, 15, 3, -1, 1'b0, -1);
    send_tri(0, 0, 0, 4, 4, 0);
    scan_tri(0, 0, 4, 0, 4, 15, 3, 3, 1'b1, -1);

    // Full-grid box; strict count is the 15 interior points (area 24.5, 21 boundary points)
    send_tri(7, 0, 0, 7, 7, 7);
    scan_tri(1, 0, 7, 0, 7, 36, 15, -1, 1'b0, -1);

    send_tri(3, 3, 3, 3, 3, 3);
    scan_tri(2, 3, 3, 3, 3, 1, 0, -1, 1'b0, -1);

    send_tri(0, 0, 2, 2, 4, 4);
    scan_tri(3, 0, 4, 0, 4, 5, 0, -1, 1'b0, -1);

    // Reset mid-scan aborts without done, then a fresh triangle scans normally
    send_tri(0, 0, 4, 0, 0, 4);
    scan_tri(0, 0, 4, 0, 4, 15, 3, -1, 1'b0, 6);
    reset_n = 1'b0;
    #1;
    check_eq("abort_ov", int'(ov), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_xo", int'(xo), 0);
    check_eq("abort_yo", int'(yo), 0);
    check_eq("abort_done", int'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    ordy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("post_abort_done", int'(done), 0);
      check_eq("post_abort_busy", int'(busy), 0);
    end
    send_tri(0, 0, 2, 2, 4, 4);
    scan_tri(3, 0, 4, 0, 4, 5, 0, -1, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
